mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for a small MIPS subset (IF/ID/EX/MEM/WB, plus ERR on memory timeout).
// Define MC_CTRL_MDU_EN to decode mult/div/mfhi/mflo and enable the MDW wait state.
module mc_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       imem_rdy,
    input  logic       dmem_rdy,
    input  logic       alu_zero,
    input  logic       md_busy,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [2:0] alu_op,
    output logic       alu_bsrc,
    output logic       ext_op,
    output logic       md_start,
    output logic [2:0] state,
    output logic       illegal,
    output logic       mem_err
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_MDW = 3'd5,
        S_ERR = 3'd7
    } state_t;

    state_t     cur, nxt;
    logic [7:0] wait_cnt;
    logic       waiting, at_limit;
    logic       is_rtype, is_addu, is_subu, is_jr, is_nop, is_ori, is_lui;
    logic       is_lw, is_sw, is_beq, is_j, is_jal, is_md, is_mf, legal;
    logic [2:0] dec_alu_op;
    logic       dec_bsrc, dec_ext;

    always_comb begin
        is_rtype = (op == 6'h00);
        is_addu  = is_rtype && (func == 6'h21);
        is_subu  = is_rtype && (func == 6'h23);
        is_jr    = is_rtype && (func == 6'h08);
        is_nop   = is_rtype && (func == 6'h00);
        is_ori   = (op == 6'h0D);
        is_lui   = (op == 6'h0F);
        is_lw    = (op == 6'h23);
        is_sw    = (op == 6'h2B);
        is_beq   = (op == 6'h04);
        is_j     = (op == 6'h02);
        is_jal   = (op == 6'h03);
`ifdef MC_CTRL_MDU_EN
        is_md    = is_rtype && ((func == 6'h18) || (func == 6'h1A));
        is_mf    = is_rtype && ((func == 6'h10) || (func == 6'h12));
`else
        is_md    = 1'b0;
        is_mf    = 1'b0;
`endif
        legal    = is_addu || is_subu || is_jr || is_nop || is_ori || is_lui || is_lw
                || is_sw || is_beq || is_j || is_jal || is_md || is_mf;
    end

    // ALU controls depend only on the instruction, so they stay stable from EX through WB.
    always_comb begin
        dec_alu_op = 3'd0;
        dec_bsrc   = 1'b0;
        dec_ext    = 1'b0;
        if (is_subu || is_beq) dec_alu_op = 3'd1;
        if (is_ori) begin
            dec_alu_op = 3'd2;
            dec_bsrc   = 1'b1;
        end
        if (is_lui) begin
            dec_alu_op = 3'd3;
            dec_bsrc   = 1'b1;
        end
        if (is_lw || is_sw) begin
            dec_bsrc = 1'b1;
            dec_ext  = 1'b1;
        end
    end

    assign waiting  = ((cur == S_IF) && !imem_rdy) || ((cur == S_MEM) && !dmem_rdy);
    assign at_limit = (wait_cnt == 8'(TIMEOUT - 1));
    assign state    = cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= S_IF;
            wait_cnt <= 8'd0;
        end else begin
            cur <= nxt;
            if (nxt != cur) wait_cnt <= 8'd0;
            else if (waiting) wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        nxt      = cur;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        pc_src   = 2'd0;
        reg_dst  = 2'd0;
        wd_sel   = 2'd0;
        alu_op   = 3'd0;
        alu_bsrc = 1'b0;
        ext_op   = 1'b0;
        md_start = 1'b0;
        illegal  = 1'b0;
        mem_err  = 1'b0;
        case (cur)
            S_IF: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = S_ID;
                end else if (at_limit) begin
                    nxt = S_ERR;
                end
            end
            S_ID: begin
                if (!legal) begin
                    illegal = 1'b1;
                    nxt     = S_IF;
                end else if (is_j || is_jal) begin
                    pc_we  = 1'b1;
                    pc_src = 2'd2;
                    nxt    = S_IF;
                    if (is_jal) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'd2;
                        wd_sel  = 2'd2;
                    end
                end else if (is_nop) begin
                    nxt = S_IF;
                end else begin
                    nxt = S_EX;
                end
            end
            S_EX: begin
                alu_op   = dec_alu_op;
                alu_bsrc = dec_bsrc;
                ext_op   = dec_ext;
                if (is_beq) begin
                    pc_we  = alu_zero;
                    pc_src = 2'd1;
                    nxt    = S_IF;
                end else if (is_jr) begin
                    pc_we  = 1'b1;
                    pc_src = 2'd3;
                    nxt    = S_IF;
                end else if (is_lw || is_sw) begin
                    nxt = S_MEM;
                end else if (is_md) begin
                    md_start = 1'b1;
                    nxt      = S_MDW;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                alu_op   = dec_alu_op;
                alu_bsrc = dec_bsrc;
                ext_op   = dec_ext;
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_rdy) nxt = is_sw ? S_IF : S_WB;
                else if (at_limit) nxt = S_ERR;
            end
            S_WB: begin
                alu_op   = dec_alu_op;
                alu_bsrc = dec_bsrc;
                ext_op   = dec_ext;
                reg_we   = 1'b1;
                if (is_rtype) begin
                    reg_dst = 2'd1;
                    wd_sel  = is_mf ? 2'd3 : 2'd0;
                end else if (is_lw) begin
                    wd_sel = 2'd1;
                end
                nxt = S_IF;
            end
`ifdef MC_CTRL_MDU_EN
            S_MDW: begin
                if (!md_busy) nxt = S_IF;
            end
`endif
            S_ERR: begin
                mem_err = 1'b1;
            end
            default: nxt = S_IF;
        endcase
        // Reset dominates combinationally so no write enable can escape while it is held.
        if (!reset_n) begin
            nxt      = S_IF;
            imem_req = 1'b1;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            reg_we   = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            pc_src   = 2'd0;
            reg_dst  = 2'd0;
            wd_sel   = 2'd0;
            alu_op   = 3'd0;
            alu_bsrc = 1'b0;
            ext_op   = 1'b0;
            md_start = 1'b0;
            illegal  = 1'b0;
            mem_err  = 1'b0;
        end
    end

`ifndef MC_CTRL_MDU_EN
    logic unused_md_busy;
    assign unused_md_busy = md_busy;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed and randomized instruction runs checked cycle by cycle against
// per-instruction expected traces built from the instruction-level rules.
module tb_mc_ctrl;
    localparam int TIMEOUT = 16;
`ifdef MC_CTRL_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2, ST_MEM = 3'd3,
                           ST_WB = 3'd4, ST_MDW = 3'd5, ST_ERR = 3'd7;

    localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_NOP = 3, K_ORI = 4, K_LUI = 5,
                   K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10, K_MULT = 11,
                   K_DIV = 12, K_MFHI = 13, K_MFLO = 14, K_ILL = 15;

    logic       clk, reset_n;
    logic [5:0] op, func;
    logic       imem_rdy, dmem_rdy, alu_zero, md_busy;
    logic       imem_req, dmem_req, dmem_we, pc_we, ir_we, reg_we;
    logic [1:0] pc_src, reg_dst, wd_sel;
    logic [2:0] alu_op;
    logic       alu_bsrc, ext_op, md_start;
    logic [2:0] state;
    logic       illegal, mem_err;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, dmem_req, dmem_we, pc_we, ir_we, reg_we;
        logic [1:0] pc_src, reg_dst, wd_sel;
        logic [2:0] alu_op;
        logic       alu_bsrc, ext_op, md_start, illegal, mem_err;
    } out_t;

    typedef struct {
        out_t exp;
        logic irdy, drdy, az, busy;
    } cyc_t;

    int vectors = 0;
    int miscompares = 0;

    mc_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .func(func),
        .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .alu_zero(alu_zero), .md_busy(md_busy),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .pc_we(pc_we),
        .ir_we(ir_we), .reg_we(reg_we), .pc_src(pc_src), .reg_dst(reg_dst), .wd_sel(wd_sel),
        .alu_op(alu_op), .alu_bsrc(alu_bsrc), .ext_op(ext_op), .md_start(md_start),
        .state(state), .illegal(illegal), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    function automatic out_t observed();
        out_t o;
        o.st = state;         o.imem_req = imem_req; o.dmem_req = dmem_req;
        o.dmem_we = dmem_we;  o.pc_we = pc_we;       o.ir_we = ir_we;
        o.reg_we = reg_we;    o.pc_src = pc_src;     o.reg_dst = reg_dst;
        o.wd_sel = wd_sel;    o.alu_op = alu_op;     o.alu_bsrc = alu_bsrc;
        o.ext_op = ext_op;    o.md_start = md_start; o.illegal = illegal;
        o.mem_err = mem_err;
        return o;
    endfunction

    task automatic check(input string tag, input out_t exp);
        out_t obs;
        obs = observed();
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic out_t rst_vec();
        out_t o;
        o = '0;
        o.imem_req = 1'b1;
        return o;
    endfunction

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c.exp      = '0;
        c.exp.st   = st;
        c.irdy     = 1'($urandom);
        c.drdy     = 1'($urandom);
        c.az       = 1'($urandom);
        c.busy     = 1'($urandom);
        return c;
    endfunction

    function automatic bit legal_spec(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03: return 1'b1;
            6'h00: begin
                case (f)
                    6'h21, 6'h23, 6'h08, 6'h00:  return 1'b1;
                    6'h18, 6'h1A, 6'h10, 6'h12:  return MDU;
                    default:                     return 1'b0;
                endcase
            end
            default: return 1'b0;
        endcase
    endfunction

    // ALU control values an instruction carries in EX/MEM/WB.
    function automatic out_t alu_of(input int k);
        out_t a;
        a = '0;
        case (k)
            K_SUBU, K_BEQ: a.alu_op = 3'd1;
            K_ORI: begin a.alu_op = 3'd2; a.alu_bsrc = 1'b1; end
            K_LUI: begin a.alu_op = 3'd3; a.alu_bsrc = 1'b1; end
            K_LW, K_SW: begin a.alu_bsrc = 1'b1; a.ext_op = 1'b1; end
            default: ;
        endcase
        return a;
    endfunction

    task automatic run_instr(input string tag, input int kind_in, input logic [5:0] iop,
                             input logic [5:0] ifn, input int di, input int dd,
                             input logic az, input int nb, input int stop_after);
        cyc_t q[$];
        cyc_t c;
        out_t a;
        int   kind, n;
        bit   dead;
        kind = kind_in;
        if (!MDU && kind >= K_MULT && kind <= K_MFLO) kind = K_ILL;
        a    = alu_of(kind);
        dead = 1'b0;
        for (int k = 0; k < di && k < TIMEOUT; k++) begin
            c = blank(ST_IF); c.exp.imem_req = 1'b1; c.irdy = 1'b0; q.push_back(c);
        end
        if (di >= TIMEOUT) begin
            for (int k = 0; k < 3; k++) begin
                c = blank(ST_ERR); c.exp.mem_err = 1'b1; q.push_back(c);
            end
            dead = 1'b1;
        end
        if (!dead) begin
            c = blank(ST_IF); c.irdy = 1'b1;
            c.exp.imem_req = 1'b1; c.exp.ir_we = 1'b1; c.exp.pc_we = 1'b1;
            q.push_back(c);
            c = blank(ST_ID);
            case (kind)
                K_J:   begin c.exp.pc_we = 1'b1; c.exp.pc_src = 2'd2; end
                K_JAL: begin
                    c.exp.pc_we = 1'b1; c.exp.pc_src = 2'd2;
                    c.exp.reg_we = 1'b1; c.exp.reg_dst = 2'd2; c.exp.wd_sel = 2'd2;
                end
                K_ILL: c.exp.illegal = 1'b1;
                default: ;
            endcase
            q.push_back(c);
            if (kind inside {K_J, K_JAL, K_NOP, K_ILL}) dead = 1'b1;
        end
        if (!dead) begin
            c = blank(ST_EX);
            c.exp.alu_op = a.alu_op; c.exp.alu_bsrc = a.alu_bsrc; c.exp.ext_op = a.ext_op;
            case (kind)
                K_BEQ:        begin c.az = az; c.exp.pc_we = az; c.exp.pc_src = 2'd1; end
                K_JR:         begin c.exp.pc_we = 1'b1; c.exp.pc_src = 2'd3; end
                K_MULT, K_DIV: c.exp.md_start = 1'b1;
                default: ;
            endcase
            q.push_back(c);
            if (kind inside {K_BEQ, K_JR}) dead = 1'b1;
        end
        if (!dead && (kind == K_LW || kind == K_SW)) begin
            for (int k = 0; k <= dd && k <= TIMEOUT; k++) begin
                if (k == TIMEOUT) break;
                c = blank(ST_MEM);
                c.exp.dmem_req = 1'b1; c.exp.dmem_we = (kind == K_SW);
                c.exp.alu_op = a.alu_op; c.exp.alu_bsrc = a.alu_bsrc; c.exp.ext_op = a.ext_op;
                c.drdy = (k == dd);
                q.push_back(c);
            end
            if (dd >= TIMEOUT) begin
                for (int k = 0; k < 3; k++) begin
                    c = blank(ST_ERR); c.exp.mem_err = 1'b1; q.push_back(c);
                end
                dead = 1'b1;
            end
            if (kind == K_SW) dead = 1'b1;
        end
        if (!dead && (kind == K_MULT || kind == K_DIV)) begin
            for (int k = 0; k <= nb; k++) begin
                c = blank(ST_MDW); c.busy = (k < nb); q.push_back(c);
            end
            dead = 1'b1;
        end
        if (!dead) begin
            c = blank(ST_WB);
            c.exp.reg_we = 1'b1;
            c.exp.alu_op = a.alu_op; c.exp.alu_bsrc = a.alu_bsrc; c.exp.ext_op = a.ext_op;
            if (kind inside {K_ADDU, K_SUBU, K_MFHI, K_MFLO}) c.exp.reg_dst = 2'd1;
            if (kind == K_LW) c.exp.wd_sel = 2'd1;
            if (kind inside {K_MFHI, K_MFLO}) c.exp.wd_sel = 2'd3;
            q.push_back(c);
        end
        n = (stop_after < 0 || stop_after > q.size()) ? q.size() : stop_after;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            imem_rdy = q[i].irdy;
            dmem_rdy = q[i].drdy;
            alu_zero = q[i].az;
            md_busy  = q[i].busy;
            if (q[i].exp.st == ST_IF) begin
                op = 6'($urandom); func = 6'($urandom);
            end else begin
                op = iop; func = ifn;
            end
            #1 check($sformatf("%s_c%0d", tag, i), q[i].exp);
        end
    endtask

    task automatic run_kind(input string tag, input int kind, input int di, input int dd,
                            input logic az, input int nb, input int stop_after);
        logic [5:0] o, f;
        o = 6'h00;
        f = 6'($urandom);
        case (kind)
            K_ADDU: f = 6'h21;   K_SUBU: f = 6'h23;   K_JR:   f = 6'h08;
            K_NOP:  f = 6'h00;   K_MULT: f = 6'h18;   K_DIV:  f = 6'h1A;
            K_MFHI: f = 6'h10;   K_MFLO: f = 6'h12;
            K_ORI:  o = 6'h0D;   K_LUI:  o = 6'h0F;   K_LW:   o = 6'h23;
            K_SW:   o = 6'h2B;   K_BEQ:  o = 6'h04;   K_J:    o = 6'h02;
            K_JAL:  o = 6'h03;
            default: begin
                do begin
                    o = 6'($urandom);
                    f = 6'($urandom);
                end while (legal_spec(o, f));
            end
        endcase
        run_instr(tag, kind, o, f, di, dd, az, nb, stop_after);
    endtask

    // Asserts reset between clock edges with every strobe high, then releases it just after a rising edge.
    task automatic do_reset(input string tag);
        imem_rdy = 1'b1; dmem_rdy = 1'b1; alu_zero = 1'b1; md_busy = 1'b1;
        op = 6'h03; func = 6'h21;
        reset_n = 1'b0;
        #1 check({tag, "_async"}, rst_vec());
        @(posedge clk);
        #1 check({tag, "_hold"}, rst_vec());
        @(posedge clk);
        #1 reset_n = 1'b1;
        imem_rdy = 1'b0; dmem_rdy = 1'b0;
        #1 check({tag, "_after"}, rst_vec());
    endtask

    initial begin
        int k, di, dd, stop;
        reset_n = 1'b1;
        op = 6'h00; func = 6'h00;
        imem_rdy = 1'b0; dmem_rdy = 1'b0; alu_zero = 1'b0; md_busy = 1'b0;
        #1 do_reset("por");

        run_kind("addu",      K_ADDU, 0, 0, 1'b0, 0, -1);
        run_kind("lw_d3",     K_LW,   0, 3, 1'b0, 0, -1);
        run_kind("beq_nt",    K_BEQ,  0, 0, 1'b0, 0, -1);
        run_kind("beq_tk",    K_BEQ,  0, 0, 1'b1, 0, -1);
        run_instr("ill_3f",   K_ILL, 6'h3F, 6'($urandom), 0, 0, 1'b0, 0, -1);
        run_kind("j",         K_J,    1, 0, 1'b0, 0, -1);
        run_kind("jal",       K_JAL,  0, 0, 1'b0, 0, -1);
        run_kind("jr",        K_JR,   2, 0, 1'b0, 0, -1);
        run_kind("nop",       K_NOP,  0, 0, 1'b0, 0, -1);
        run_kind("sw",        K_SW,   0, 1, 1'b0, 0, -1);
        run_kind("ori",       K_ORI,  0, 0, 1'b0, 0, -1);
        run_kind("lui",       K_LUI,  0, 0, 1'b0, 0, -1);
        run_kind("subu",      K_SUBU, 0, 0, 1'b0, 0, -1);
        run_kind("mult",      K_MULT, 0, 0, 1'b0, 5, -1);
        run_kind("mfhi",      K_MFHI, 0, 0, 1'b0, 0, -1);
        run_kind("if_edge",   K_ADDU, TIMEOUT - 1, 0, 1'b0, 0, -1);
        run_kind("mem_edge",  K_SW,   0, TIMEOUT - 1, 1'b0, 0, -1);

        run_kind("if_to",     K_ADDU, TIMEOUT, 0, 1'b0, 0, -1);
        do_reset("rst_err_if");
        run_kind("mem_to",    K_LW,   0, TIMEOUT, 1'b0, 0, -1);
        do_reset("rst_err_mem");
        run_kind("abort_lw",  K_LW,   0, 4, 1'b0, 0, 3);
        do_reset("rst_abort");

        for (int i = 0; i < 80; i++) begin
            k  = int'($urandom_range(0, 15));
            di = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
            dd = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
            stop = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 4)) : -1;
            run_kind($sformatf("rnd%0d_k%0d", i, k), k, di, dd, 1'($urandom),
                     int'($urandom_range(0, 6)), stop);
            if (stop >= 0) do_reset($sformatf("rnd%0d_rst", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
